// File: rtl/io_ctrl.sv
// Memory-mapped I/O port: synchronized input with change detect, output register,
// status/control register with interrupt, and a read mux aligned to memory latency.
module io_ctrl #(
  parameter int                 NBITS   = 8,
  parameter logic [NBITS-3:0]   IO_DATA = 'h3F,
  parameter logic [NBITS-3:0]   IO_STAT = 'h3E
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-3:0] memAddress,
  input  logic [NBITS-1:0] memWriteData,
  input  logic             memMemWrite,
  input  logic [NBITS-1:0] ReadData,
  output logic [NBITS-1:0] memReadData,
  input  logic [NBITS-1:0] entrada,
  output logic [NBITS-1:0] saida,
  output logic             interrupt
);

  typedef enum logic [1:0] {
    SEL_MEM  = 2'd0,
    SEL_DATA = 2'd1,
    SEL_STAT = 2'd2
  } rsel_t;

  logic [NBITS-1:0] s1, s2, guarda_ent;
  logic             pend, ien, ovr;
  logic             pend_next, ien_next, ovr_next;
  logic             change, wr_stat, wr_data, pend_clr, ovr_clr;
  logic [NBITS-1:0] status, rdat, rdat_next;
  rsel_t            rsel, rsel_next;

  assign change   = (s2 != guarda_ent);
  assign wr_stat  = memMemWrite && (memAddress == IO_STAT);
  assign wr_data  = memMemWrite && (memAddress == IO_DATA);
  assign pend_clr = wr_stat && memWriteData[0];
  assign ovr_clr  = wr_stat && memWriteData[2];
  assign status   = {{(NBITS-3){1'b0}}, ovr, ien, pend};

  // A change always wins over a same-cycle clear, and only flags overrun when
  // the pending event was not being acknowledged in that same cycle.
  always_comb begin
    pend_next = pend;
    ovr_next  = ovr;
    ien_next  = ien;
    if (change)        pend_next = 1'b1;
    else if (pend_clr) pend_next = 1'b0;
    if (change && pend && !pend_clr) ovr_next = 1'b1;
    else if (ovr_clr)                ovr_next = 1'b0;
    if (wr_stat) ien_next = memWriteData[1];
  end

  always_comb begin
    rsel_next = SEL_MEM;
    rdat_next = '0;
    if (memAddress == IO_DATA) begin
      rsel_next = SEL_DATA;
      rdat_next = guarda_ent;
    end else if (memAddress == IO_STAT) begin
      rsel_next = SEL_STAT;
      rdat_next = status;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1         <= '0;
      s2         <= '0;
      guarda_ent <= '0;
      saida      <= '0;
      pend       <= 1'b0;
      ien        <= 1'b0;
      ovr        <= 1'b0;
      interrupt  <= 1'b0;
      rsel       <= SEL_MEM;
      rdat       <= '0;
    end else begin
      s1         <= entrada;
      s2         <= s1;
      guarda_ent <= s2;
      if (wr_data) saida <= memWriteData;
      pend       <= pend_next;
      ien        <= ien_next;
      ovr        <= ovr_next;
      // Driven from the registered flags, so the request trails them by one edge.
      interrupt  <= pend & ien;
      rsel       <= rsel_next;
      rdat       <= rdat_next;
    end
  end

  assign memReadData = (rsel == SEL_MEM) ? ReadData : rdat;

endmodule
